// File: rtl/dsm_pkg.sv
// rtl/dsm_pkg.sv - shared constants, saturation result type and clamp helper
package dsm_pkg;

  localparam int DSM_GUARD = 3;
  localparam int CNT_W     = 16;

  typedef struct packed {
    logic signed [31:0] val;
    logic               hit;
  } sat_res_t;

  // Clamp a wide sum to the range of a (w + DSM_GUARD)-bit signed integrator.
  function automatic sat_res_t sat(input logic signed [31:0] a, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    sat_res_t           r;
    hi = (32'sd1 <<< (w + DSM_GUARD - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w + DSM_GUARD - 1));
    if (a > hi) begin
      r.val = hi;
      r.hit = 1'b1;
    end else if (a < lo) begin
      r.val = lo;
      r.hit = 1'b1;
    end else begin
      r.val = a;
      r.hit = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/dsm2_core.sv
// rtl/dsm2_core.sv - second-order single-bit delta-sigma loop with saturating integrators
module dsm2_core
  import dsm_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] x,
  output logic                bit_out,
  output logic                sat_hit
);

  localparam int                 SW = W + DSM_GUARD;
  localparam logic signed [31:0] FS = 32'sd1 <<< (W - 1);

  logic signed [SW-1:0] r_s1;
  logic signed [SW-1:0] r_s2;
  logic                 w_b;
  logic signed [31:0]   w_v;
  logic signed [31:0]   w_sum1;
  logic signed [31:0]   w_sum2;
  sat_res_t             w_r1;
  sat_res_t             w_r2;

  assign w_b    = ~r_s2[SW-1];
  assign w_v    = w_b ? FS : -FS;
  // Both integrators read the old s1, giving the z^-2 signal delay.
  assign w_sum1 = 32'(r_s1) + 32'(x) - w_v;
  assign w_sum2 = 32'(r_s2) + 32'(r_s1) - (w_v <<< 1);
  assign w_r1   = sat(w_sum1, W);
  assign w_r2   = sat(w_sum2, W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1    <= '0;
      r_s2    <= '0;
      bit_out <= 1'b0;
      sat_hit <= 1'b0;
    end else begin
      r_s1    <= SW'(w_r1.val);
      r_s2    <= SW'(w_r2.val);
      bit_out <= w_b;
      sat_hit <= w_r1.hit | w_r2.hit;
    end
  end

endmodule

// File: rtl/iq_dsm_modulator.sv
// rtl/iq_dsm_modulator.sv - I/Q zero-order-hold interpolator feeding two delta-sigma loops
module iq_dsm_modulator
  import dsm_pkg::*;
#(
  parameter int W   = 16,
  parameter int OSR = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [W-1:0] s_i,
  input  logic signed [W-1:0] s_q,
  output logic                data_i,
  output logic                data_q,
  output logic                underrun,
  output logic                overload
);

  logic [CNT_W-1:0]    r_cnt;
  logic signed [W-1:0] r_cur_i;
  logic signed [W-1:0] r_cur_q;
  logic signed [W-1:0] r_nxt_i;
  logic signed [W-1:0] r_nxt_q;
  logic                r_nxt_full;
  logic                r_underrun;
  logic                w_wrap;
  logic                w_hs;
  logic                w_sat_i;
  logic                w_sat_q;

  assign w_wrap   = (r_cnt == CNT_W'(OSR - 1));
  assign w_hs     = s_valid && !r_nxt_full;
  assign s_ready  = !r_nxt_full;
  assign underrun = r_underrun;
  assign overload = w_sat_i | w_sat_q;

  // A wrap with an empty buffer keeps the old sample; a same-cycle offer only fills nxt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_cur_i    <= '0;
      r_cur_q    <= '0;
      r_nxt_i    <= '0;
      r_nxt_q    <= '0;
      r_nxt_full <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_cnt      <= w_wrap ? '0 : r_cnt + 1'b1;
      r_underrun <= w_wrap && !r_nxt_full;
      if (w_wrap && r_nxt_full) begin
        r_cur_i    <= r_nxt_i;
        r_cur_q    <= r_nxt_q;
        r_nxt_full <= 1'b0;
      end else if (w_hs) begin
        r_nxt_i    <= s_i;
        r_nxt_q    <= s_q;
        r_nxt_full <= 1'b1;
      end
    end
  end

  dsm2_core #(.W(W)) u_core_i (
    .clk     (clk),
    .rst     (rst),
    .x       (r_cur_i),
    .bit_out (data_i),
    .sat_hit (w_sat_i)
  );

  dsm2_core #(.W(W)) u_core_q (
    .clk     (clk),
    .rst     (rst),
    .x       (r_cur_q),
    .bit_out (data_q),
    .sat_hit (w_sat_q)
  );

endmodule

// File: tb/tb_iq_dsm_modulator.sv
// tb/tb_iq_dsm_modulator.sv - directed self-checking bench for iq_dsm_modulator
module tb_iq_dsm_modulator;

  localparam int W   = 16;
  localparam int OSR = 64;
  localparam int LO  = -(1 << (W + 2));
  localparam int HI  = (1 << (W + 2)) - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                s_valid;
  logic                s_ready;
  logic signed [W-1:0] s_i;
  logic signed [W-1:0] s_q;
  logic                data_i;
  logic                data_q;
  logic                underrun;
  logic                overload;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iq_dsm_modulator #(.W(W), .OSR(OSR)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_i      (s_i),
    .s_q      (s_q),
    .data_i   (data_i),
    .data_q   (data_q),
    .underrun (underrun),
    .overload (overload)
  );

  // Release lands on a falling edge, so the next rising edge is cycle 0 with cnt = 0.
  task automatic apply_reset;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_i     = '0;
    s_q     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_i     = '0;
    s_q     = '0;
    @(negedge clk);
    #1;
    checks++;
    if ({data_i, data_q, underrun, overload} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0000", {data_i, data_q, underrun, overload});
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", s_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 70; k++) begin
      s_valid = (k == 0 || k == 64);
      s_i     = (k == 0) ? 16'sd1000 : 16'sd2000;
      s_q     = (k == 0) ? -16'sd1000 : -16'sd2000;
      @(negedge clk);
    end
    s_valid = 1'b0;
    checks++;
    if (s_ready !== 1'b0 || dut.r_cur_i !== 16'sd1000) begin
      errors++;
      $display("FAIL pre_reset_state got ready=%b cur_i=%0d want ready=0 cur_i=1000", s_ready, dut.r_cur_i);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({data_i, data_q, underrun, overload} !== 4'b0000 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got out=%b ready=%b want out=0000 ready=1",
               {data_i, data_q, underrun, overload}, s_ready);
    end
    checks++;
    if (dut.r_cur_i !== '0 || dut.r_cur_q !== '0 || dut.u_core_i.r_s1 !== '0 || dut.u_core_i.r_s2 !== '0) begin
      errors++;
      $display("FAIL async_reset_state got cur_i=%0d s1=%0d s2=%0d want 0 0 0",
               dut.r_cur_i, dut.u_core_i.r_s1, dut.u_core_i.r_s2);
    end
    s_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (dut.r_nxt_full !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_blocks_handshake got nxt_full=%b ready=%b want 0 1", dut.r_nxt_full, s_ready);
    end
    s_valid = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    checks++;
    if (data_i !== 1'b1 || data_q !== 1'b1) begin
      errors++;
      $display("FAIL first_bit got i=%b q=%b want 1 1", data_i, data_q);
    end
  endtask

  task automatic test_zero;
    bit exp_bits [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int bad = 0;
    apply_reset();
    s_valid = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      if (k >= 1) begin
        checks++;
        if (data_i !== exp_bits[(k - 1) % 4] || data_q !== exp_bits[(k - 1) % 4]) begin
          errors++;
          bad++;
          if (bad < 4)
            $display("FAIL zero_pattern cyc=%0d got i=%b q=%b want %b", k - 1, data_i, data_q, exp_bits[(k - 1) % 4]);
        end
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_dc;
    int ones_i = 0;
    int ones_q = 0;
    int ov     = 0;
    apply_reset();
    s_i     = 16'sd16384;
    s_q     = '0;
    s_valid = 1'b1;
    repeat (200) @(negedge clk);
    for (int k = 0; k < 4096; k++) begin
      ones_i += int'(data_i);
      ones_q += int'(data_q);
      if (overload) ov++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    checks++;
    if (ones_i < 3068 || ones_i > 3076) begin
      errors++;
      $display("FAIL dc_half_density got %0d want 3072+-4", ones_i);
    end
    checks++;
    if (ones_q != 2048) begin
      errors++;
      $display("FAIL dc_q_zero_density got %0d want 2048", ones_q);
    end
    checks++;
    if (ov != 0) begin
      errors++;
      $display("FAIL dc_no_overload got %0d pulses want 0", ov);
    end
  endtask

  task automatic test_back_to_back;
    int hs = 0;
    int un = 0;
    apply_reset();
    s_valid = 1'b1;
    for (int k = 0; k < 10 * OSR; k++) begin
      s_i = W'(k);
      s_q = W'(-k);
      if (s_valid && s_ready) hs++;
      if (underrun) un++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    checks++;
    if (hs != 10) begin
      errors++;
      $display("FAIL held_valid_handshakes got %0d want 10", hs);
    end
    checks++;
    if (un != 0) begin
      errors++;
      $display("FAIL held_valid_underrun got %0d want 0", un);
    end
  endtask

  task automatic test_wrap_offer;
    int un = 0;
    apply_reset();
    s_i = 16'sd12345;
    s_q = -16'sd222;
    for (int k = 0; k < 130; k++) begin
      s_valid = (k == OSR - 1);
      if (underrun) un++;
      if (k == OSR) begin
        checks++;
        if (dut.r_nxt_full !== 1'b1 || dut.r_cur_i !== '0) begin
          errors++;
          $display("FAIL wrap_offer_lands_nxt got nxt_full=%b cur_i=%0d want 1 0", dut.r_nxt_full, dut.r_cur_i);
        end
      end
      if (k == 2 * OSR) begin
        checks++;
        if (dut.r_cur_i !== 16'sd12345 || dut.r_cur_q !== -16'sd222) begin
          errors++;
          $display("FAIL wrap_offer_promote got cur_i=%0d cur_q=%0d want 12345 -222", dut.r_cur_i, dut.r_cur_q);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (un != 1) begin
      errors++;
      $display("FAIL wrap_offer_underrun got %0d want 1", un);
    end
  endtask

  task automatic test_underrun;
    int un   = 0;
    int ones = 0;
    apply_reset();
    s_i = 16'sd8192;
    s_q = 16'sd8192;
    for (int k = 0; k < 8 * OSR; k++) begin
      s_valid = (k == 0);
      if (underrun) un++;
      if (k >= 4 * OSR) ones += int'(data_i);
      @(negedge clk);
    end
    checks++;
    if (un != 6) begin
      errors++;
      $display("FAIL underrun_pulses got %0d want 6", un);
    end
    checks++;
    if (ones < 156 || ones > 164) begin
      errors++;
      $display("FAIL underrun_hold_density got %0d want 160+-4", ones);
    end
    checks++;
    if (dut.r_cur_i !== 16'sd8192) begin
      errors++;
      $display("FAIL underrun_cur_held got %0d want 8192", dut.r_cur_i);
    end
  endtask

  task automatic test_overload;
    int ov       = 0;
    int early_ov = 0;
    int bnd      = 0;
    int xs       = 0;
    int min_s2   = 0;
    int s1v;
    int s2v;
    apply_reset();
    s_q = '0;
    for (int k = 0; k < 2 * OSR + 1000; k++) begin
      s_valid = (k == 0 || k >= OSR);
      s_i     = (k == 0) ? 16'sd256 : 16'sh8000;
      if ($isunknown({data_i, data_q, underrun, overload, s_ready})) xs++;
      if (overload) begin
        ov++;
        if (k <= 2 * OSR) early_ov++;
      end
      s1v = int'(dut.u_core_i.r_s1);
      s2v = int'(dut.u_core_i.r_s2);
      if (s1v < LO || s1v > HI || s2v < LO || s2v > HI) bnd++;
      if (s2v < min_s2) min_s2 = s2v;
      @(negedge clk);
    end
    s_valid = 1'b0;
    checks++;
    if (ov == 0) begin
      errors++;
      $display("FAIL overload_pulses got 0 want >0");
    end
    checks++;
    if (early_ov != 0) begin
      errors++;
      $display("FAIL overload_before_fullscale got %0d want 0", early_ov);
    end
    checks++;
    if (bnd != 0) begin
      errors++;
      $display("FAIL overload_bounds got %0d violations want 0", bnd);
    end
    checks++;
    if (min_s2 != LO) begin
      errors++;
      $display("FAIL overload_clamp_value got min_s2=%0d want %0d", min_s2, LO);
    end
    checks++;
    if (xs != 0) begin
      errors++;
      $display("FAIL overload_no_x got %0d unknown samples want 0", xs);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_dc();
    test_back_to_back();
    test_wrap_offer();
    test_underrun();
    test_overload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
